// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the round countdown timer: FSM state codes,
// active-low 7-segment patterns and the digit decoder.
package countdown_timer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic [3:0] mins;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_time_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/countdown_timer_tick_divider.sv
// One-second prescaler: counts down while run is high and emits a one-cycle
// tick when the count sits at zero, then reloads.
module tick_divider #(
    parameter int TICK_DIV = 50000000
) (
    input  logic Clock,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = run && (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = RELOAD;
        end else if (run) begin
            count_d = (count_q == '0) ? RELOAD : count_q - 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Round countdown timer: loads a preset M:SS, decrements once per tick and
// pulses time_up on reaching 0:00. Drives three active-low 7-seg digits.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int START_MIN  = 0,
    parameter int START_TENS = 3,
    parameter int START_ONES = 0
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic       running,
    output logic       done,
    output logic       time_up
);

    localparam bcd_time_t PRESET = '{
        mins: 4'(START_MIN),
        tens: 4'(START_TENS),
        ones: 4'(START_ONES)
    };
    localparam logic PRESET_ZERO = (PRESET == '0);

    logic [1:0] state_q, state_d;
    bcd_time_t  time_q, time_d;
    bcd_time_t  dec_time;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       time_up_q, time_up_d;
    logic       presc_clear;
    logic       tick;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .Clock (Clock),
        .reset (reset),
        .run   (state_q == ST_RUN),
        .clear (presc_clear),
        .tick  (tick)
    );

    // BCD borrow chain; only used when time_q is non-zero, so minutes never wrap.
    always_comb begin
        dec_time = time_q;
        if (time_q.ones == 4'd0) begin
            dec_time.ones = 4'd9;
            if (time_q.tens == 4'd0) begin
                dec_time.tens = 4'd5;
                dec_time.mins = time_q.mins - 4'd1;
            end else begin
                dec_time.tens = time_q.tens - 4'd1;
            end
        end else begin
            dec_time.ones = time_q.ones - 4'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        time_up_d   = 1'b0;
        presc_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (abort) begin
                    time_d      = PRESET;
                    presc_clear = 1'b1;
                end else if (start) begin
                    time_d      = PRESET;
                    presc_clear = 1'b1;
                    if (PRESET_ZERO) begin
                        state_d   = ST_DONE;
                        time_up_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    time_d      = PRESET;
                    presc_clear = 1'b1;
                end else if (tick) begin
                    // A 0:00 preset restarted from DONE ends on its first tick.
                    if (time_q == '0 || dec_time == '0) begin
                        time_d    = '0;
                        state_d   = ST_DONE;
                        time_up_d = 1'b1;
                    end else begin
                        time_d  = dec_time;
                        state_d = pause ? ST_PAUSE : ST_RUN;
                    end
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    time_d      = PRESET;
                    presc_clear = 1'b1;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    time_d      = PRESET;
                    presc_clear = 1'b1;
                end else if (start) begin
                    state_d     = ST_RUN;
                    time_d      = PRESET;
                    presc_clear = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                time_d      = PRESET;
                presc_clear = 1'b1;
            end
        endcase
    end

    assign running_d = (state_d == ST_RUN);
    assign done_d    = (state_d == ST_DONE);

    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            time_q    <= PRESET;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            time_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            running_q <= running_d;
            done_q    <= done_d;
            time_up_q <= time_up_d;
        end
    end

    assign running = running_q;
    assign done    = done_q;
    assign time_up = time_up_q;

    logic [3:0] digit_w [3];
    logic [6:0] hex_w   [3];

    assign digit_w[0] = time_q.ones;
    assign digit_w[1] = time_q.tens;
    assign digit_w[2] = time_q.mins;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dec
        assign hex_w[gi] = seg_decode(digit_w[gi]);
    end

    assign HEX0 = hex_w[0];
    assign HEX1 = hex_w[1];
    assign HEX2 = hex_w[2];

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: three instances (presets 0:12, 1:00,
// 0:00) share stimulus; expected outputs are queued and checked after each edge.
module tb_countdown_timer;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic reset, start, pause, abort;
    logic [6:0] hex0 [3];
    logic [6:0] hex1 [3];
    logic [6:0] hex2 [3];
    logic       run_o  [3];
    logic       done_o [3];
    logic       tup_o  [3];

    countdown_timer #(.TICK_DIV(4), .START_MIN(0), .START_TENS(1), .START_ONES(2)) u_a (
        .Clock(Clock), .reset(reset), .start(start), .pause(pause), .abort(abort),
        .HEX0(hex0[0]), .HEX1(hex1[0]), .HEX2(hex2[0]),
        .running(run_o[0]), .done(done_o[0]), .time_up(tup_o[0]));

    countdown_timer #(.TICK_DIV(4), .START_MIN(1), .START_TENS(0), .START_ONES(0)) u_b (
        .Clock(Clock), .reset(reset), .start(start), .pause(pause), .abort(abort),
        .HEX0(hex0[1]), .HEX1(hex1[1]), .HEX2(hex2[1]),
        .running(run_o[1]), .done(done_o[1]), .time_up(tup_o[1]));

    countdown_timer #(.TICK_DIV(4), .START_MIN(0), .START_TENS(0), .START_ONES(0)) u_z (
        .Clock(Clock), .reset(reset), .start(start), .pause(pause), .abort(abort),
        .HEX0(hex0[2]), .HEX1(hex1[2]), .HEX2(hex2[2]),
        .running(run_o[2]), .done(done_o[2]), .time_up(tup_o[2]));

    typedef struct {
        int          inst;
        logic [23:0] exp;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic expect_out(input int inst, input int m, input int t, input int o,
                              input logic r, input logic dn, input logic tu, input string tag);
        exp_t e;
        e.inst = inst;
        e.exp  = {seg(m), seg(t), seg(o), r, dn, tu};
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    // Advance one clock, then compare every queued expectation against the DUTs.
    task automatic cyc();
        exp_t        e;
        logic [23:0] obs;
        @(posedge Clock);
        #1;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = {hex2[e.inst], hex1[e.inst], hex0[e.inst],
                   run_o[e.inst], done_o[e.inst], tup_o[e.inst]};
            vectors++;
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s inst=%0d observed=%h expected=%h", e.tag, e.inst, obs, e.exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        cyc();
        expect_out(0, 0, 1, 2, 0, 0, 0, "reset_a");
        expect_out(1, 1, 0, 0, 0, 0, 0, "reset_b");
        expect_out(2, 0, 0, 0, 0, 0, 0, "reset_z");
        cyc();
        reset = 1'b0;

        // Start accepted on this edge; the 0:00 instance jumps straight to DONE.
        start = 1'b1;
        expect_out(0, 0, 1, 2, 1, 0, 0, "start_a");
        expect_out(1, 1, 0, 0, 1, 0, 0, "start_b");
        expect_out(2, 0, 0, 0, 0, 1, 1, "zero_done");
        cyc();
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            expect_out(0, 0, 1, 2, 1, 0, 0, "hold_first_sec");
            if (i == 1) expect_out(2, 0, 0, 0, 0, 1, 0, "zero_pulse_end");
            cyc();
        end
        expect_out(0, 0, 1, 1, 1, 0, 0, "first_tick");
        expect_out(1, 0, 5, 9, 1, 0, 0, "borrow_1_00");
        cyc();

        // Count 0:11 down to 0:00, one decrement every four cycles.
        for (int v = 10; v >= 0; v--) begin
            for (int c = 0; c < 4; c++) begin
                if (c < 3)
                    expect_out(0, 0, (v + 1) / 10, (v + 1) % 10, 1, 0, 0, "countdown_hold");
                else if (v == 0)
                    expect_out(0, 0, 0, 0, 0, 1, 1, "time_up_pulse");
                else
                    expect_out(0, 0, v / 10, v % 10, 1, 0, 0, "countdown_step");
                cyc();
            end
        end
        expect_out(0, 0, 0, 0, 0, 1, 0, "done_hold");
        cyc();
        expect_out(0, 0, 0, 0, 0, 1, 0, "done_hold2");
        cyc();

        // Restart from DONE, then pause for 10 cycles with one prescaler count left.
        start = 1'b1;
        expect_out(0, 0, 1, 2, 1, 0, 0, "restart_from_done");
        expect_out(2, 0, 0, 0, 1, 0, 0, "zero_restart");
        cyc();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expect_out(0, 0, 1, 2, 1, 0, 0, "pre_pause");
            cyc();
        end
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            expect_out(0, 0, 1, 2, 0, 0, 0, "paused");
            cyc();
        end
        pause = 1'b0;
        expect_out(0, 0, 1, 2, 1, 0, 0, "resume");
        cyc();
        expect_out(0, 0, 1, 1, 1, 0, 0, "resume_tick");
        cyc();

        abort = 1'b1;
        expect_out(0, 0, 1, 2, 0, 0, 0, "abort_run");
        cyc();
        abort = 1'b0;

        // Run a full round and abort on the terminal tick.
        start = 1'b1;
        expect_out(0, 0, 1, 2, 1, 0, 0, "start_again");
        cyc();
        start = 1'b0;
        for (int i = 0; i < 46; i++) cyc();
        expect_out(0, 0, 0, 1, 1, 0, 0, "pre_terminal");
        cyc();
        abort = 1'b1;
        expect_out(0, 0, 1, 2, 0, 0, 0, "abort_terminal");
        cyc();
        abort = 1'b0;
        expect_out(0, 0, 1, 2, 0, 0, 0, "no_time_up");
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
